// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: start synchronizer, game state machine, and lives/score/level bookkeeping.
// Every output comes straight from a register, so the display and datapath never see glitches.
module frogger_game_ctrl #(
    parameter int unsigned c_LIVES        = 3,
    parameter int unsigned c_GOAL_Y       = 0,
    parameter int unsigned c_MAX_SCORE    = 99,
    parameter int unsigned c_DEATH_FRAMES = 60,
    parameter int unsigned c_WIN_FRAMES   = 60,
    parameter int unsigned c_GRACE_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Frame_Tick,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic [2:0] o_State,
    output logic       o_Game_Active,
    output logic       o_Frog_Reset,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic [3:0] o_Level,
    output logic       o_Flash
);

    localparam logic [1:0] lp_LIVES     = 2'(c_LIVES);
    localparam logic [5:0] lp_GOAL_Y    = 6'(c_GOAL_Y);
    localparam logic [6:0] lp_MAX_SCORE = 7'(c_MAX_SCORE);
    localparam logic [7:0] lp_DEATH     = 8'(c_DEATH_FRAMES);
    localparam logic [7:0] lp_WIN       = 8'(c_WIN_FRAMES);
    localparam logic [7:0] lp_GRACE     = 8'(c_GRACE_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_DYING     = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_start_prev;
    logic       w_start_edge;

    logic [1:0] r_lives;
    logic [6:0] r_score;
    logic [3:0] r_level;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_grace_cnt;
    logic       r_frog_reset;
    logic       r_flash;
    logic       r_game_active;

    logic [1:0] w_lives_nxt;
    logic [6:0] w_score_nxt;
    logic [3:0] w_level_nxt;
    logic [7:0] w_frame_nxt;
    logic [7:0] w_grace_nxt;
    logic       w_frog_reset_nxt;
    logic       w_flash_nxt;
    logic       w_game_active_nxt;

    logic       w_armed;
    logic       w_goal;
    logic       w_death_done;
    logic       w_win_done;

    // Two flops tame metastability on the raw button; the third gives a single-cycle rising edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts one stage per clock.
            r_sync1      <= i_Game_Start;
            r_sync2      <= r_sync1;
            r_start_prev <= r_sync2;
        end
    end

    assign w_start_edge = r_sync2 & ~r_start_prev;
    assign w_armed      = (r_grace_cnt == lp_GRACE);
    assign w_goal       = (i_Frogger_Y == lp_GOAL_Y);
    assign w_death_done = i_Frame_Tick && ((r_frame_cnt + 8'd1) == lp_DEATH);
    assign w_win_done   = i_Frame_Tick && ((r_frame_cnt + 8'd1) == lp_WIN);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_GAME_OVER: if (w_start_edge) w_state_nxt = S_PLAY;
            S_PLAY: begin
                // A collision outranks reaching home when both happen together.
                if (w_armed && i_Collided) w_state_nxt = S_DYING;
                else if (w_goal)           w_state_nxt = S_LEVEL_UP;
            end
            S_DYING:    if (w_death_done) w_state_nxt = (r_lives == 2'd0) ? S_GAME_OVER : S_PLAY;
            S_LEVEL_UP: if (w_win_done)   w_state_nxt = S_PLAY;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_level_nxt = r_level;
        w_grace_nxt = r_grace_cnt;
        w_frame_nxt = r_frame_cnt;

        if (w_state_nxt != r_state) begin
            w_frame_nxt = 8'd0;
        end else if (i_Frame_Tick && (r_state == S_DYING || r_state == S_LEVEL_UP)) begin
            w_frame_nxt = r_frame_cnt + 8'd1;
        end

        if (w_state_nxt == S_PLAY && r_state != S_PLAY) begin
            w_grace_nxt = 8'd0;
        end else if (r_state == S_PLAY && i_Frame_Tick && r_grace_cnt < lp_GRACE) begin
            w_grace_nxt = r_grace_cnt + 8'd1;
        end

        if ((r_state == S_IDLE || r_state == S_GAME_OVER) && w_state_nxt == S_PLAY) begin
            w_lives_nxt = lp_LIVES;
            w_score_nxt = 7'd0;
            w_level_nxt = 4'd1;
        end else if (r_state == S_PLAY && w_state_nxt == S_DYING) begin
            w_lives_nxt = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
        end else if (r_state == S_PLAY && w_state_nxt == S_LEVEL_UP) begin
            w_score_nxt = (r_score >= lp_MAX_SCORE) ? lp_MAX_SCORE : r_score + 7'd1;
            w_level_nxt = (r_level == 4'd15) ? 4'd15 : r_level + 4'd1;
        end

        w_frog_reset_nxt  = (w_state_nxt == S_PLAY) && (r_state != S_PLAY);
        w_game_active_nxt = (w_state_nxt == S_PLAY);
        w_flash_nxt       = (w_state_nxt == S_DYING) && w_frame_nxt[3];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_lives       <= 2'd0;
            r_score       <= 7'd0;
            r_level       <= 4'd0;
            r_frame_cnt   <= 8'd0;
            r_grace_cnt   <= 8'd0;
            r_frog_reset  <= 1'b0;
            r_flash       <= 1'b0;
            r_game_active <= 1'b0;
        end else begin
            r_lives       <= w_lives_nxt;
            r_score       <= w_score_nxt;
            r_level       <= w_level_nxt;
            r_frame_cnt   <= w_frame_nxt;
            r_grace_cnt   <= w_grace_nxt;
            r_frog_reset  <= w_frog_reset_nxt;
            r_flash       <= w_flash_nxt;
            r_game_active <= w_game_active_nxt;
        end
    end

    assign o_State       = r_state;
    assign o_Game_Active = r_game_active;
    assign o_Frog_Reset  = r_frog_reset;
    assign o_Lives       = r_lives;
    assign o_Score       = r_score;
    assign o_Level       = r_level;
    assign o_Flash       = r_flash;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Self-checking bench for frogger_game_ctrl: directed game scenarios plus random play,
// compared every cycle against a game-rules model kept in plain integers.
module tb_frogger_game_ctrl;

    localparam int LIVES = 3;
    localparam int GOAL_Y = 0;
    localparam int MAX_SCORE = 99;
    localparam int DEATH_FRAMES = 60;
    localparam int WIN_FRAMES = 60;
    localparam int GRACE_FRAMES = 2;

    localparam int ST_IDLE = 0;
    localparam int ST_PLAY = 1;
    localparam int ST_DYING = 2;
    localparam int ST_LEVEL_UP = 3;
    localparam int ST_GAME_OVER = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       coll = 1'b0;
    logic [5:0] y = 6'd10;

    logic [2:0] o_State;
    logic       o_Game_Active;
    logic       o_Frog_Reset;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic [3:0] o_Level;
    logic       o_Flash;

    int n_vec = 0;
    int n_err = 0;

    // Game-rules model: each quantity is an integer, updated once per clock edge.
    int m_state, m_lives, m_score, m_level, m_grace, m_frame, m_frog_reset;
    bit m_seen [3];

    frogger_game_ctrl dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Frame_Tick (tick),
        .i_Game_Start (start),
        .i_Collided   (coll),
        .i_Frogger_Y  (y),
        .o_State      (o_State),
        .o_Game_Active(o_Game_Active),
        .o_Frog_Reset (o_Frog_Reset),
        .o_Lives      (o_Lives),
        .o_Score      (o_Score),
        .o_Level      (o_Level),
        .o_Flash      (o_Flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_lives = 0; m_score = 0; m_level = 0;
        m_grace = 0; m_frame = 0; m_frog_reset = 0;
        for (int i = 0; i < 3; i++) m_seen[i] = 1'b0;
    endtask

    // Start edge seen at edge n is the button sampled at n-2 being high while n-3 was low.
    task automatic model_edge();
        bit edge_now;
        edge_now = m_seen[1] && !m_seen[2];
        m_seen[2] = m_seen[1];
        m_seen[1] = m_seen[0];
        m_seen[0] = start;
        m_frog_reset = 0;
        case (m_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (edge_now) begin
                    m_state = ST_PLAY; m_lives = LIVES; m_score = 0; m_level = 1;
                    m_grace = 0; m_frame = 0; m_frog_reset = 1;
                end
            end
            ST_PLAY: begin
                if (m_grace == GRACE_FRAMES && coll) begin
                    m_state = ST_DYING; m_frame = 0;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end else if (y == GOAL_Y) begin
                    m_state = ST_LEVEL_UP; m_frame = 0;
                    m_score = (m_score + 1 > MAX_SCORE) ? MAX_SCORE : m_score + 1;
                    m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
                end else if (tick && m_grace < GRACE_FRAMES) begin
                    m_grace++;
                end
            end
            ST_DYING, ST_LEVEL_UP: begin
                if (tick) begin
                    m_frame++;
                    if (m_frame == ((m_state == ST_DYING) ? DEATH_FRAMES : WIN_FRAMES)) begin
                        m_frame = 0;
                        if (m_state == ST_DYING && m_lives == 0) begin
                            m_state = ST_GAME_OVER;
                        end else begin
                            m_state = ST_PLAY; m_grace = 0; m_frog_reset = 1;
                        end
                    end
                end
            end
            default: m_state = ST_IDLE;
        endcase
    endtask

    task automatic compare();
        check("state", o_State, m_state);
        check("game_active", o_Game_Active, (m_state == ST_PLAY) ? 1 : 0);
        check("frog_reset", o_Frog_Reset, m_frog_reset);
        check("lives", o_Lives, m_lives);
        check("score", o_Score, m_score);
        check("level", o_Level, m_level);
        check("flash", o_Flash, (m_state == ST_DYING) ? ((m_frame >> 3) & 1) : 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare();
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (int'(o_State) != s && n < budget) begin
            step();
            n++;
        end
        if (int'(o_State) != s) check("wait_state_timeout", o_State, s);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // Let the grace window elapse, then collide once; leaves the game in DYING.
    task automatic collide_after_grace();
        coll = 1'b0; y = 6'd10;
        ticks(GRACE_FRAMES);
        coll = 1'b1;
        step();
        coll = 1'b0;
    endtask

    task automatic score_goal();
        y = 6'd0;
        step();
        y = 6'd10;
        ticks(WIN_FRAMES);
    endtask

    initial begin
        int pulses;
        model_reset();
        #2 rst_n = 1'b0;
        #2;
        check("rst_state", o_State, 0);
        check("rst_lives", o_Lives, 0);
        check("rst_score", o_Score, 0);
        check("rst_level", o_Level, 0);
        check("rst_frog_reset", o_Frog_Reset, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle ignores collision and goal.
        for (int i = 0; i < 6; i++) begin
            coll = 1'($urandom_range(0, 1));
            y = 6'($urandom_range(0, 3));
            tick = 1'($urandom_range(0, 1));
            step();
        end
        coll = 1'b0; y = 6'd10; tick = 1'b0;

        // Start latency: high at edge k, PLAY at edge k+2, one pulse for a held button.
        start = 1'b1;
        step();
        check("start_k", o_State, ST_IDLE);
        step();
        check("start_k1", o_State, ST_IDLE);
        step();
        check("start_k2_state", o_State, ST_PLAY);
        check("start_k2_lives", o_Lives, 3);
        check("start_k2_level", o_Level, 1);
        pulses = int'(o_Frog_Reset);
        for (int i = 0; i < 100; i++) begin
            step();
            pulses += int'(o_Frog_Reset);
        end
        check("start_single_pulse", pulses, 1);

        // Grace: collision held, ignored until two ticks have passed.
        coll = 1'b1;
        repeat (5) step();
        check("grace_no_tick", o_State, ST_PLAY);
        ticks(1);
        step();
        check("grace_one_tick", o_State, ST_PLAY);
        ticks(1);
        check("grace_second_tick", o_State, ST_PLAY);
        step();
        check("grace_then_dying", o_State, ST_DYING);
        check("dying_lives", o_Lives, 2);
        coll = 1'b0;

        // DYING: flash follows frame-count bit 3, back to PLAY on the 60th tick.
        tick = 1'b1;
        for (int i = 1; i <= DEATH_FRAMES; i++) begin
            step();
            if (i == 8 || i == 15 || i == 16 || i == 24 || i == 59)
                check("flash_literal", o_Flash, (i >> 3) & 1);
        end
        tick = 1'b0;
        check("respawn_state", o_State, ST_PLAY);
        check("respawn_pulse", o_Frog_Reset, 1);

        collide_after_grace();
        ticks(DEATH_FRAMES);
        collide_after_grace();
        ticks(DEATH_FRAMES);
        check("game_over_state", o_State, ST_GAME_OVER);
        check("game_over_lives", o_Lives, 0);

        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        wait_state(ST_PLAY, 6);
        check("restart_lives", o_Lives, 3);
        check("restart_score", o_Score, 0);

        score_goal();
        check("goal_score", o_Score, 1);
        check("goal_level", o_Level, 2);
        check("goal_back_play", o_State, ST_PLAY);

        // Collision and goal together: collision wins, score untouched.
        coll = 1'b0; y = 6'd10;
        ticks(GRACE_FRAMES);
        coll = 1'b1; y = 6'd0;
        step();
        coll = 1'b0; y = 6'd10;
        check("both_state", o_State, ST_DYING);
        check("both_score", o_Score, 1);
        ticks(DEATH_FRAMES);

        repeat (4) score_goal();
        check("pre_reset_score", o_Score, 5);

        // Asynchronous reset mid-game takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_state", o_State, 0);
        check("midrst_score", o_Score, 0);
        check("midrst_lives", o_Lives, 0);
        check("midrst_active", o_Game_Active, 0);
        check("midrst_frog_reset", o_Frog_Reset, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_state(ST_PLAY, 6);

        repeat (100) score_goal();
        check("sat_score", o_Score, 99);
        check("sat_level", o_Level, 15);
        score_goal();
        check("sat_score_again", o_Score, 99);

        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 3) == 0);
            coll = ($urandom_range(0, 15) == 0);
            y = ($urandom_range(0, 31) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            if ($urandom_range(0, 49) == 0) start = ~start;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
